// File: rtl/vc_buffer_if.sv
// ---------------------------------------------------------------------------
// vc_buffer_if
//   Bundle of the write port, read port and status signals of vc_buffer.
//
//   master : the user side. It drives the write/read requests and observes
//            the read data and the flags. This is the link receiver plus the
//            switch allocator, or a testbench.
//   slave  : the buffer itself.
//
//   Signals
//     wr_en, wr_vc, wr_data        write request, target VC, flit
//     rd_en, rd_vc                 read request, source VC
//     rd_data, rd_valid, rd_vc_out registered read response
//     empty, full, afull           per-VC occupancy flags
//     ovf_err, udf_err             sticky error flags
// ---------------------------------------------------------------------------
interface vc_buffer_if #(
    parameter int DATA_W = 10,
    parameter int NUM_VC = 4,
    parameter int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
    logic              wr_en;
    logic [VCW-1:0]    wr_vc;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [VCW-1:0]    rd_vc;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [VCW-1:0]    rd_vc_out;
    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] afull;
    logic              ovf_err;
    logic              udf_err;

    modport master (
        output wr_en, wr_vc, wr_data, rd_en, rd_vc,
        input  rd_data, rd_valid, rd_vc_out, empty, full, afull, ovf_err, udf_err
    );

    modport slave (
        input  wr_en, wr_vc, wr_data, rd_en, rd_vc,
        output rd_data, rd_valid, rd_vc_out, empty, full, afull, ovf_err, udf_err
    );
endinterface

// File: rtl/vc_buffer.sv
// ---------------------------------------------------------------------------
// vc_buffer
//   Router input buffer that holds NUM_VC independent FIFO queues of DEPTH
//   flits each. There is one shared write port and one shared read port, and
//   each port picks its VC every cycle. A write and a read may both happen in
//   the same cycle, to the same VC or to different VCs.
//
//   Ports
//     clk  clock
//     rst  synchronous, active-high reset
//     bus  vc_buffer_if.slave, which carries the write and read ports, the
//          per-VC empty/full/afull flags and the sticky ovf_err/udf_err flags
//
//   Handshake
//     wr_en and rd_en are requests. They have no ready signal.
//     A write is accepted when wr_en is high, wr_vc is in range and full[wr_vc]
//     is low. A read is accepted when rd_en is high, rd_vc is in range and
//     empty[rd_vc] is low.
//     The flags come from the registered counts, so a read in the same cycle
//     never frees space for a write, and a write in the same cycle never feeds
//     a read.
//     A refused request is dropped and sets its sticky error flag.
//     An accepted read raises rd_valid for exactly the next cycle. During that
//     cycle rd_data and rd_vc_out carry the flit and the VC it came from.
// ---------------------------------------------------------------------------
module vc_buffer #(
    parameter int DATA_W   = 10,
    parameter int DEPTH    = 4,
    parameter int NUM_VC   = 4,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic        clk,
    input  logic        rst,
    vc_buffer_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_TH);

    // Storage is not reset. Every VC is empty after reset, so stale
    // contents are never read.
    logic [DATA_W-1:0] mem_q [NUM_VC][DEPTH];

    logic [AW-1:0]     wp_q  [NUM_VC];
    logic [AW-1:0]     wp_d  [NUM_VC];
    logic [AW-1:0]     rp_q  [NUM_VC];
    logic [AW-1:0]     rp_d  [NUM_VC];
    logic [AW:0]       cnt_q [NUM_VC];
    logic [AW:0]       cnt_d [NUM_VC];

    logic [NUM_VC-1:0] empty_w;
    logic [NUM_VC-1:0] full_w;
    logic [NUM_VC-1:0] afull_w;
    logic [NUM_VC-1:0] wr_acc_v;
    logic [NUM_VC-1:0] rd_acc_v;
    logic              wr_acc;
    logic              rd_acc;

    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic [VCW-1:0]    rd_vc_out_q;
    logic [VCW-1:0]    rd_vc_out_d;
    logic              rd_valid_q;
    logic              ovf_q;
    logic              udf_q;

    // The VC selects are widened to 32 bits. This lets the range check
    // against NUM_VC stay meaningful when NUM_VC is not a power of two.
    logic [31:0]       wr_vc_ext;
    logic [31:0]       rd_vc_ext;

    assign wr_vc_ext = 32'(bus.wr_vc);
    assign rd_vc_ext = 32'(bus.rd_vc);

    always_comb begin
        rd_data_d   = rd_data_q;
        rd_vc_out_d = rd_vc_out_q;
        empty_w     = '0;
        full_w      = '0;
        afull_w     = '0;
        wr_acc_v    = '0;
        rd_acc_v    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            empty_w[v]  = (cnt_q[v] == '0);
            full_w[v]   = (cnt_q[v] == DEPTH_C);
            afull_w[v]  = (cnt_q[v] >= AFULL_C);
            wr_acc_v[v] = bus.wr_en && (wr_vc_ext == 32'(v)) && !full_w[v];
            rd_acc_v[v] = bus.rd_en && (rd_vc_ext == 32'(v)) && !empty_w[v];
            wp_d[v]     = wp_q[v] + AW'(wr_acc_v[v]);
            rp_d[v]     = rp_q[v] + AW'(rd_acc_v[v]);
            cnt_d[v]    = cnt_q[v] + (AW+1)'(wr_acc_v[v]) - (AW+1)'(rd_acc_v[v]);
            if (rd_acc_v[v]) begin
                rd_data_d   = mem_q[v][rp_q[v]];
                rd_vc_out_d = VCW'(v);
            end
        end
    end

    assign wr_acc = |wr_acc_v;
    assign rd_acc = |rd_acc_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wp_q[v]  <= '0;
                rp_q[v]  <= '0;
                cnt_q[v] <= '0;
            end
            rd_data_q   <= '0;
            rd_vc_out_q <= '0;
            rd_valid_q  <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                wp_q[v]  <= wp_d[v];
                rp_q[v]  <= rp_d[v];
                cnt_q[v] <= cnt_d[v];
            end
            rd_data_q   <= rd_data_d;
            rd_vc_out_q <= rd_vc_out_d;
            rd_valid_q  <= rd_acc;
            if (bus.wr_en && !wr_acc) ovf_q <= 1'b1;
            if (bus.rd_en && !rd_acc) udf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (!rst && wr_acc_v[v]) begin
                mem_q[v][wp_q[v]] <= bus.wr_data;
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_vc_out = rd_vc_out_q;
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.afull     = afull_w;
    assign bus.ovf_err   = ovf_q;
    assign bus.udf_err   = udf_q;

endmodule

// File: tb/tb_vc_buffer.sv
// ---------------------------------------------------------------------------
// tb_vc_buffer
//   Directed bench for vc_buffer with DATA_W=10, DEPTH=4, NUM_VC=4 and
//   AFULL_TH=3.
//   The stimulus thread pushes {vc, flit} into exp_q for each read it expects
//   to be accepted. The monitor pops exp_q on every rd_valid pulse.
//   Flags are checked directly, one cycle after the edge they depend on.
// ---------------------------------------------------------------------------
module tb_vc_buffer;
    localparam int DATA_W = 10;
    localparam int DEPTH  = 4;
    localparam int NUM_VC = 4;

    logic clk;
    logic rst;

    vc_buffer_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC)) bus ();

    vc_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC), .AFULL_TH(DEPTH - 1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;
    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int v0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic we, input logic [1:0] wvc, input logic [9:0] wd,
                        input logic re, input logic [1:0] rvc);
        bus.wr_en   = we;
        bus.wr_vc   = wvc;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_vc   = rvc;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] vc, input logic [9:0] d);
        step(1'b1, vc, d, 1'b0, 2'd0);
    endtask

    task automatic rd_exp(input logic [1:0] vc, input logic [9:0] d);
        exp_q.push_back({vc, d});
        step(1'b0, 2'd0, 10'd0, 1'b1, vc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_vc_out", 32'(bus.rd_vc_out), 32'(mon_e[11:10]));
                check("rd_data", 32'(bus.rd_data), 32'(mon_e[9:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int rv;
        int k;
        logic [9:0] e;
        bus.wr_en = 1'b0; bus.wr_vc = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_vc = '0;
        rst = 1'b1;

        // Test 1: reset values, then three flits through VC2
        do_reset();
        check("rst_empty", 32'(bus.empty), 32'hF);
        check("rst_full", 32'(bus.full), 32'h0);
        check("rst_afull", 32'(bus.afull), 32'h0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h0);
        check("rst_rd_vc_out", 32'(bus.rd_vc_out), 32'h0);
        check("rst_errs", 32'({bus.ovf_err, bus.udf_err}), 32'h0);
        wr(2'd2, 10'h011);
        check("t1_empty_after_wr", 32'(bus.empty), 32'hB);
        wr(2'd2, 10'h022);
        wr(2'd2, 10'h033);
        check("t1_afull2", 32'(bus.afull), 32'h4);
        rd_exp(2'd2, 10'h011);
        check("t1_valid_c1", 32'(bus.rd_valid), 32'h1);
        rd_exp(2'd2, 10'h022);
        check("t1_valid_c2", 32'(bus.rd_valid), 32'h1);
        rd_exp(2'd2, 10'h033);
        check("t1_valid_c3", 32'(bus.rd_valid), 32'h1);
        check("t1_empty_end", 32'(bus.empty), 32'hF);
        check("t1_errs", 32'({bus.ovf_err, bus.udf_err}), 32'h0);

        // Test 2: fill VC0, overflow, drain
        wr(2'd0, 10'h0A1);
        wr(2'd0, 10'h0A2);
        check("t2_afull_cnt2", 32'(bus.afull[0]), 32'h0);
        wr(2'd0, 10'h0A3);
        check("t2_afull_cnt3", 32'(bus.afull[0]), 32'h1);
        check("t2_full_cnt3", 32'(bus.full[0]), 32'h0);
        wr(2'd0, 10'h0A4);
        check("t2_full_cnt4", 32'(bus.full), 32'h1);
        check("t2_ovf_before", 32'(bus.ovf_err), 32'h0);
        wr(2'd0, 10'h3FF);
        check("t2_ovf", 32'(bus.ovf_err), 32'h1);
        check("t2_full_after_ovf", 32'(bus.full), 32'h1);
        rd_exp(2'd0, 10'h0A1);
        rd_exp(2'd0, 10'h0A2);
        rd_exp(2'd0, 10'h0A3);
        rd_exp(2'd0, 10'h0A4);
        check("t2_empty_end", 32'(bus.empty), 32'hF);
        check("t2_ovf_sticky", 32'(bus.ovf_err), 32'h1);
        check("t2_udf", 32'(bus.udf_err), 32'h0);

        // Test 3: underflow, then write+read on an empty VC
        do_reset();
        check("t3_errs_cleared", 32'({bus.ovf_err, bus.udf_err}), 32'h0);
        wr(2'd0, 10'h155);
        rd_exp(2'd0, 10'h155);
        step(1'b0, 2'd0, 10'd0, 1'b1, 2'd1);
        check("t3_udf_valid", 32'(bus.rd_valid), 32'h0);
        check("t3_udf", 32'(bus.udf_err), 32'h1);
        check("t3_rd_data_hold", 32'(bus.rd_data), 32'h155);
        check("t3_rd_vc_hold", 32'(bus.rd_vc_out), 32'h0);
        step(1'b1, 2'd1, 10'h1AB, 1'b1, 2'd1);
        check("t3_wr_rd_empty1", 32'(bus.empty[1]), 32'h0);
        check("t3_wr_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("t3_ovf", 32'(bus.ovf_err), 32'h0);
        rd_exp(2'd1, 10'h1AB);
        check("t3_cnt1_was_1", 32'(bus.empty), 32'hF);

        // Test 4: interleaved write/read on different VCs with pointer wrap
        do_reset();
        for (int v = 0; v < 4; v++) wr(2'(v), 10'(32'h200 + v));
        for (int i = 0; i < 16; i++) begin
            rv = (i + 1) % 4;
            k  = i / 4;
            if (k == 0) e = 10'(32'h200 + rv);
            else        e = 10'(32'h300 + 4 * (k - 1) + rv);
            exp_q.push_back({2'(rv), e});
            step(1'b1, 2'(i % 4), 10'(32'h300 + i), 1'b1, 2'(rv));
        end
        check("t4_errs", 32'({bus.ovf_err, bus.udf_err}), 32'h0);
        check("t4_empty", 32'(bus.empty), 32'h0);
        check("t4_full", 32'(bus.full), 32'h0);

        // Test 5: VC3 held at count 2 with write+read every cycle
        do_reset();
        wr(2'd3, 10'h050);
        wr(2'd3, 10'h051);
        v0 = n_valid;
        for (int i = 0; i < 20; i++) begin
            if (i == 0)      e = 10'h050;
            else if (i == 1) e = 10'h051;
            else             e = 10'(32'h060 + i - 2);
            exp_q.push_back({2'd3, e});
            step(1'b1, 2'd3, 10'(32'h060 + i), 1'b1, 2'd3);
            if (i == 10) begin
                check("t5_empty3_mid", 32'(bus.empty[3]), 32'h0);
                check("t5_afull3_mid", 32'(bus.afull[3]), 32'h0);
            end
        end
        rd_exp(2'd3, 10'h072);
        rd_exp(2'd3, 10'h073);
        @(negedge clk);
        #1;
        check("t5_valid_count", 32'(n_valid - v0), 32'd22);
        check("t5_empty_end", 32'(bus.empty), 32'hF);
        check("t5_errs", 32'({bus.ovf_err, bus.udf_err}), 32'h0);

        // Test 6: reset in the middle of traffic
        wr(2'd0, 10'h0E1);
        wr(2'd0, 10'h0E2);
        wr(2'd1, 10'h0E3);
        step(1'b0, 2'd0, 10'd0, 1'b1, 2'd3);
        check("t6_udf_pre", 32'(bus.udf_err), 32'h1);
        rd_exp(2'd0, 10'h0E1);
        rst = 1'b1;
        bus.wr_en = 1'b1; bus.wr_vc = 2'd2; bus.wr_data = 10'h3AA;
        bus.rd_en = 1'b1; bus.rd_vc = 2'd1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("t6_empty", 32'(bus.empty), 32'hF);
        check("t6_full", 32'(bus.full), 32'h0);
        check("t6_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("t6_rd_data", 32'(bus.rd_data), 32'h0);
        check("t6_errs", 32'({bus.ovf_err, bus.udf_err}), 32'h0);
        wr(2'd1, 10'h2CD);
        check("t6_empty_after_wr", 32'(bus.empty), 32'hD);
        rd_exp(2'd1, 10'h2CD);
        check("t6_empty_end", 32'(bus.empty), 32'hF);

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
